// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout,
// forwarding-source encoding and the register-match helper.
package id_ex_stage_pkg;

    // Packed control bundle layout (bit positions inside id_ctrl/ex_ctrl).
    localparam int CTRL_W          = 12;
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_LSB = 5;
    localparam int CTRL_ALU_OP_MSB = 8;
    localparam int CTRL_BRANCH     = 9;
    // Bits 10..11 are reserved for future decode fields.

    localparam int REG_IDX_W = 5;

    // Where a forwarded operand comes from.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // A later-stage write targets this source register. x0 never matches,
    // so reads of x0 always keep the register-file zero.
    function automatic logic rd_match(input logic                 we,
                                      input logic [REG_IDX_W-1:0] rd,
                                      input logic [REG_IDX_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding select for one EX source: EX/MEM result beats
// MEM/WB result, which beats the operand captured at ID/EX.
module id_ex_stage_forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [REG_IDX_W-1:0] ex_rs_i,
    input  logic [W-1:0]         stored_i,
    input  logic                 exmem_we_i,
    input  logic [REG_IDX_W-1:0] exmem_rd_i,
    input  logic [W-1:0]         exmem_result_i,
    input  logic                 memwb_we_i,
    input  logic [REG_IDX_W-1:0] memwb_rd_i,
    input  logic [W-1:0]         memwb_result_i,
    output logic [W-1:0]         op_o
);

    fwd_sel_e sel;

    // Pick the youngest in-flight producer of ex_rs_i, if any.
    always_comb begin
        sel  = FWD_NONE;
        op_o = stored_i;
        if (rd_match(exmem_we_i, exmem_rd_i, ex_rs_i)) begin
            sel = FWD_EXMEM;
        end else if (rd_match(memwb_we_i, memwb_rd_i, ex_rs_i)) begin
            sel = FWD_MEMWB;
        end
        case (sel)
            FWD_EXMEM: op_o = exmem_result_i;
            FWD_MEMWB: op_o = memwb_result_i;
            default:   op_o = stored_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// writeback bypass on capture, EX operand forwarding and saturating
// stall/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int N      = 32,
    parameter int CTRL_N = CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 id_valid_i,
    input  logic [N-1:0]         id_pc_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic [REG_IDX_W-1:0] id_rd_i,
    input  logic [N-1:0]         id_rs1_data_i,
    input  logic [N-1:0]         id_rs2_data_i,
    input  logic [N-1:0]         id_imm_i,
    input  logic [CTRL_N-1:0]    id_ctrl_i,
    input  logic                 flush_i,
    input  logic                 exmem_reg_write_i,
    input  logic                 memwb_reg_write_i,
    input  logic [REG_IDX_W-1:0] exmem_rd_i,
    input  logic [REG_IDX_W-1:0] memwb_rd_i,
    input  logic [N-1:0]         exmem_result_i,
    input  logic [N-1:0]         memwb_result_i,
    output logic                 stall_o,
    output logic                 ex_valid_o,
    output logic [N-1:0]         ex_pc_o,
    output logic [N-1:0]         ex_imm_o,
    output logic [REG_IDX_W-1:0] ex_rd_o,
    output logic [REG_IDX_W-1:0] ex_rs1_o,
    output logic [REG_IDX_W-1:0] ex_rs2_o,
    output logic [CTRL_N-1:0]    ex_ctrl_o,
    output logic [N-1:0]         ex_op_a_o,
    output logic [N-1:0]         ex_op_b_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 ex_valid_q;
    logic [N-1:0]         ex_pc_q, ex_imm_q;
    logic [REG_IDX_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic [CTRL_N-1:0]    ex_ctrl_q;
    logic [N-1:0]         ex_rs1_data_q, ex_rs2_data_q;
    logic [N-1:0]         rs1_data_d, rs2_data_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                 hazard;
    logic                 bubble;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // Both sources are compared even if the instruction does not use rs2.
    always_comb begin
        hazard = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_rd_q != '0) &&
                 id_valid_i && ((ex_rd_q == id_rs1_i) || (ex_rd_q == id_rs2_i));
        stall_o = hazard && !flush_i;
        bubble  = flush_i || hazard;
    end

    // Writeback in the same cycle as the register-file read wins over the
    // stale read data, so the captured operand is already up to date.
    always_comb begin
        rs1_data_d = rd_match(memwb_reg_write_i, memwb_rd_i, id_rs1_i) ?
                     memwb_result_i : id_rs1_data_i;
        rs2_data_d = rd_match(memwb_reg_write_i, memwb_rd_i, id_rs2_i) ?
                     memwb_result_i : id_rs2_data_i;
    end

    // Pipeline register: flush or hazard injects a bubble, else capture ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_ctrl_q     <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
        end else if (bubble) begin
            // Only the fields that make EX inert are cleared; the rest hold.
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rd_q    <= '0;
        end else begin
            ex_valid_q    <= id_valid_i;
            ex_pc_q       <= id_pc_i;
            ex_imm_q      <= id_imm_i;
            ex_rd_q       <= id_rd_i;
            ex_rs1_q      <= id_rs1_i;
            ex_rs2_q      <= id_rs2_i;
            ex_ctrl_q     <= id_ctrl_i;
            ex_rs1_data_q <= rs1_data_d;
            ex_rs2_data_q <= rs2_data_d;
        end
    end

    // Saturating next-state for the performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_i && (ex_valid_q || id_valid_i) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    id_ex_stage_forward_unit #(.W(N)) u_fwd_a (
        .ex_rs_i        (ex_rs1_q),
        .stored_i       (ex_rs1_data_q),
        .exmem_we_i     (exmem_reg_write_i),
        .exmem_rd_i     (exmem_rd_i),
        .exmem_result_i (exmem_result_i),
        .memwb_we_i     (memwb_reg_write_i),
        .memwb_rd_i     (memwb_rd_i),
        .memwb_result_i (memwb_result_i),
        .op_o           (ex_op_a_o)
    );

    id_ex_stage_forward_unit #(.W(N)) u_fwd_b (
        .ex_rs_i        (ex_rs2_q),
        .stored_i       (ex_rs2_data_q),
        .exmem_we_i     (exmem_reg_write_i),
        .exmem_rd_i     (exmem_rd_i),
        .exmem_result_i (exmem_result_i),
        .memwb_we_i     (memwb_reg_write_i),
        .memwb_rd_i     (memwb_rd_i),
        .memwb_result_i (memwb_result_i),
        .op_o           (ex_op_b_o)
    );

    assign ex_valid_o  = ex_valid_q;
    assign ex_pc_o     = ex_pc_q;
    assign ex_imm_o    = ex_imm_q;
    assign ex_rd_o     = ex_rd_q;
    assign ex_rs1_o    = ex_rs1_q;
    assign ex_rs2_o    = ex_rs2_q;
    assign ex_ctrl_o   = ex_ctrl_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubble, forwarding
// priority, writeback bypass, x0, flush-over-hazard, counter saturation
// (8-bit counters so saturation is reachable quickly), async reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int N     = 32;
    localparam int CNT_W = 8;

    localparam logic [CTRL_W-1:0] C_LOAD = 12'h00B; // reg_write|mem_read|mem_to_reg
    localparam logic [CTRL_W-1:0] C_ALU  = 12'h001; // reg_write

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [N-1:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic              exmem_we, memwb_we;
    logic [4:0]        exmem_rd, memwb_rd;
    logic [N-1:0]      exmem_res, memwb_res;
    logic              stall;
    logic              ex_valid;
    logic [N-1:0]      ex_pc, ex_imm, ex_op_a, ex_op_b;
    logic [4:0]        ex_rd, ex_rs1, ex_rs2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.N(N), .CTRL_N(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .id_valid_i        (id_valid),
        .id_pc_i           (id_pc),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_rd_i           (id_rd),
        .id_rs1_data_i     (id_rs1_data),
        .id_rs2_data_i     (id_rs2_data),
        .id_imm_i          (id_imm),
        .id_ctrl_i         (id_ctrl),
        .flush_i           (flush),
        .exmem_reg_write_i (exmem_we),
        .memwb_reg_write_i (memwb_we),
        .exmem_rd_i        (exmem_rd),
        .memwb_rd_i        (memwb_rd),
        .exmem_result_i    (exmem_res),
        .memwb_result_i    (memwb_res),
        .stall_o           (stall),
        .ex_valid_o        (ex_valid),
        .ex_pc_o           (ex_pc),
        .ex_imm_o          (ex_imm),
        .ex_rd_o           (ex_rd),
        .ex_rs1_o          (ex_rs1),
        .ex_rs2_o          (ex_rs2),
        .ex_ctrl_o         (ex_ctrl),
        .ex_op_a_o         (ex_op_a),
        .ex_op_b_o         (ex_op_b),
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [CTRL_W-1:0] c);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = pc ^ 32'h0000_FFFF;
        id_ctrl     = c;
    endtask

    task automatic later_idle();
        exmem_we  = 1'b0; exmem_rd = 5'd0; exmem_res = 32'h0;
        memwb_we  = 1'b0; memwb_rd = 5'd0; memwb_res = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        later_idle();
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, C_ALU);

        // Reset held with clocks running and a valid instruction in ID.
        repeat (3) tick();
        check("rst_ex_valid", 32'(ex_valid), 32'h0);
        check("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rel_ex_valid", 32'(ex_valid), 32'h1);
        check("rel_ex_pc", ex_pc, 32'h100);

        // lw x5, 0(x2) enters EX.
        set_id(1'b1, 32'h104, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, C_LOAD);
        tick();
        // add x6, x5, x1 in ID: load-use hazard.
        set_id(1'b1, 32'h108, 5'd5, 5'd1, 5'd6, 32'hBAD0_0000, 32'h1111, C_ALU);
        #1;
        check("lu_stall", 32'(stall), 32'h1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'h0);
        check("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        check("lu_bubble_rd", 32'(ex_rd), 32'h0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'h1);
        check("lu_stall_clear", 32'(stall), 32'h0);
        // Load now in MEM; consumer is captured this edge.
        exmem_we = 1'b1; exmem_rd = 5'd5; exmem_res = 32'h0;
        tick();
        later_idle();
        memwb_we = 1'b1; memwb_rd = 5'd5; memwb_res = 32'hDEAD_BEEF;
        #1;
        check("lu_capture_pc", ex_pc, 32'h108);
        check("lu_capture_rd", 32'(ex_rd), 32'h6);
        check("lu_op_a_memwb", ex_op_a, 32'hDEAD_BEEF);
        check("lu_op_b_stored", ex_op_b, 32'h1111);
        check("lu_stall_cnt_hold", 32'(stall_cnt), 32'h1);

        // Forwarding priority on ex_rs1 = 7.
        later_idle();
        set_id(1'b1, 32'h10C, 5'd7, 5'd0, 5'd8, 32'h33, 32'h0, C_ALU);
        tick();
        exmem_we = 1'b1; exmem_rd = 5'd7; exmem_res = 32'h11;
        memwb_we = 1'b1; memwb_rd = 5'd7; memwb_res = 32'h22;
        #1;
        check("fwd_exmem_wins", ex_op_a, 32'h11);
        exmem_we = 1'b0;
        #1;
        check("fwd_memwb", ex_op_a, 32'h22);
        memwb_we = 1'b0;
        #1;
        check("fwd_none", ex_op_a, 32'h33);

        // Writeback bypass on capture for rs2 = 3.
        later_idle();
        set_id(1'b1, 32'h110, 5'd0, 5'd3, 5'd9, 32'h0, 32'h0, C_ALU);
        memwb_we = 1'b1; memwb_rd = 5'd3; memwb_res = 32'h55;
        tick();
        later_idle();
        #1;
        check("wb_bypass_op_b", ex_op_b, 32'h55);

        // x0 is never bypassed or forwarded.
        set_id(1'b1, 32'h114, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, C_ALU);
        memwb_we = 1'b1; memwb_rd = 5'd0; memwb_res = 32'h77;
        tick();
        exmem_we = 1'b1; exmem_rd = 5'd0; exmem_res = 32'h99;
        #1;
        check("x0_op_a", ex_op_a, 32'h0);
        check("x0_op_b", ex_op_b, 32'h0);
        later_idle();

        // Flush and hazard in the same cycle: flush wins.
        set_id(1'b1, 32'h118, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, C_LOAD);
        tick();
        set_id(1'b1, 32'h11C, 5'd9, 5'd2, 5'd11, 32'h0, 32'h0, C_ALU);
        flush = 1'b1;
        #1;
        check("fh_stall", 32'(stall), 32'h0);
        tick();
        check("fh_bubble_valid", 32'(ex_valid), 32'h0);
        check("fh_flush_cnt", 32'(flush_cnt), 32'h1);
        check("fh_stall_cnt", 32'(stall_cnt), 32'h1);
        // Flush with nothing valid in ID or EX is not counted.
        id_valid = 1'b0;
        tick();
        check("flush_idle_cnt", 32'(flush_cnt), 32'h1);
        flush = 1'b0;

        // Repeated load-use stalls up to and past saturation.
        for (int i = 0; i < 300; i++) begin
            set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, C_LOAD);
            tick();
            set_id(1'b1, 32'h204, 5'd0, 5'd4, 5'd12, 32'h0, 32'h0, C_ALU);
            tick();
            if (i == 252) check("sat_pre", 32'(stall_cnt), 32'd254);
        end
        check("sat_stall_cnt", 32'(stall_cnt), 32'hFF);

        // Reset asserted mid-stall clears state without a clock edge.
        set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, C_LOAD);
        tick();
        set_id(1'b1, 32'h304, 5'd4, 5'd0, 5'd13, 32'h0, 32'h0, C_ALU);
        #1;
        check("mid_stall_pre", 32'(stall), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'h0);
        check("mid_rst_valid", 32'(ex_valid), 32'h0);
        check("mid_rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("mid_rst_flush_cnt", 32'(flush_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
